// File: rtl/inst_fetch_unit.sv
// Decoupled instruction fetch: credit-limited request issue, in-order response FIFO, redirect flush.
// Define FETCH_STATS_EN to add fetched/dropped/redirect statistics counters.
module inst_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_dropped,
    output logic [31:0] stat_redirects
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [31:0]   r_fifo_data [DEPTH];
    logic [31:0]   r_fifo_pc   [DEPTH];

    logic [CW:0]   w_used;
    logic          w_credit;
    logic          w_fire;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic          w_nonempty;
    logic [31:0]   w_redirect_pc;

    assign w_redirect_pc  = redirect_pc & 32'hFFFF_FFFC;
    assign w_used         = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_credit       = w_used < LIMIT;
    assign w_nonempty     = r_count != '0;

    assign imem_req_valid = !reset && !redirect_valid && w_credit;
    assign imem_req_addr  = r_fetch_pc;
    assign w_fire         = imem_req_valid && imem_req_ready;

    // A response is stale if older than a redirect, including one landing in the redirect cycle itself.
    assign w_drop         = imem_rsp_valid && (redirect_valid || r_drop_cnt != '0);
    assign w_push         = imem_rsp_valid && !w_drop;

    assign inst_valid     = w_nonempty && !redirect_valid;
    assign w_pop          = inst_valid && inst_ready;
    assign inst           = w_nonempty ? r_fifo_data[r_rd_ptr] : '0;
    assign inst_pc        = w_nonempty ? r_fifo_pc[r_rd_ptr]   : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else begin
            case ({w_fire, imem_rsp_valid})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                r_drop_cnt <= r_outstanding - CW'(imem_rsp_valid);
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            r_fifo_data[r_wr_ptr] <= imem_rsp_data;
            r_fifo_pc[r_wr_ptr]   <= r_rsp_pc;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] r_stat_fetched;
    logic [31:0] r_stat_dropped;
    logic [31:0] r_stat_redirects;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stat_fetched   <= '0;
            r_stat_dropped   <= '0;
            r_stat_redirects <= '0;
        end else begin
            if (w_push) begin
                r_stat_fetched <= r_stat_fetched + 32'd1;
            end
            if (w_drop) begin
                r_stat_dropped <= r_stat_dropped + 32'd1;
            end
            if (redirect_valid) begin
                r_stat_redirects <= r_stat_redirects + 32'd1;
            end
        end
    end

    assign stat_fetched   = r_stat_fetched;
    assign stat_dropped   = r_stat_dropped;
    assign stat_redirects = r_stat_redirects;
`endif

endmodule
